// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: arbitrates one shared 64-bit ALU between the execute stage
// (requester 0, may update condition codes) and the auxiliary address /
// stack-pointer path (requester 1). The granted operation is registered into a
// single response slot. The block also owns the Y86-64 ZF/SF/OF register.
// Optional macro ALU_PERF_CNT_EN adds perf_g0/perf_g1/perf_conf counters.
module alu_share_ctrl #(
  parameter int FIX_PRIO     = 0,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        r0_valid,
  output logic        r0_ready,
  input  logic [1:0]  r0_op,
  input  logic [63:0] r0_a,
  input  logic [63:0] r0_b,
  input  logic        r0_set_cc,
  input  logic        r1_valid,
  output logic        r1_ready,
  input  logic [1:0]  r1_op,
  input  logic [63:0] r1_a,
  input  logic [63:0] r1_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [63:0] rsp_ans,
  output logic        rsp_of,
  output logic        cc_zf,
  output logic        cc_sf,
  output logic        cc_of
`ifdef ALU_PERF_CNT_EN
  ,
  output logic [31:0] perf_g0,
  output logic [31:0] perf_g1,
  output logic [31:0] perf_conf
`endif
);

  typedef enum logic {REQ0 = 1'b0, REQ1 = 1'b1} req_e;

  req_e        last;
  logic [3:0]  starve_cnt;
  logic        slot_free;
  logic        grant0;
  logic        grant1;
  logic        force1;
  logic [1:0]  alu_op;
  logic [63:0] alu_a;
  logic [63:0] alu_b;
  logic [63:0] alu_ans;
  logic        alu_of;

  assign slot_free = !rsp_valid || rsp_ready;
  assign r0_ready  = slot_free && grant0;
  assign r1_ready  = slot_free && grant1;

  // Exclusive grant from both valids, round-robin pointer and starvation count
  always_comb begin
    force1 = 1'b0;
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (FIX_PRIO != 0)
      force1 = (STARVE_LIMIT != 0) && (starve_cnt == 4'(STARVE_LIMIT));
    if (r0_valid && r1_valid) begin
      if (FIX_PRIO != 0)
        grant1 = force1;
      else
        grant1 = (last == REQ0);
      grant0 = !grant1;
    end else begin
      grant0 = r0_valid;
      grant1 = r1_valid;
    end
  end

  // Shared ALU driven by the granted requester's operands
  always_comb begin
    alu_op  = grant1 ? r1_op : r0_op;
    alu_a   = grant1 ? r1_a  : r0_a;
    alu_b   = grant1 ? r1_b  : r0_b;
    alu_ans = '0;
    alu_of  = 1'b0;
    case (alu_op)
      2'b00: begin
        alu_ans = alu_a + alu_b;
        alu_of  = (alu_a[63] == alu_b[63]) && (alu_ans[63] != alu_a[63]);
      end
      2'b01: begin
        alu_ans = alu_a - alu_b;
        alu_of  = (alu_a[63] != alu_b[63]) && (alu_ans[63] != alu_a[63]);
      end
      2'b10:   alu_ans = alu_a & alu_b;
      default: alu_ans = alu_a ^ alu_b;
    endcase
  end

  // Starvation counter: counts r1 losses, clears on r1 accept or r1 idle
  always_ff @(posedge clk) begin
    if (rst)
      starve_cnt <= '0;
    else if ((FIX_PRIO == 0) || !r1_valid || r1_ready)
      starve_cnt <= '0;
    else if (slot_free && grant0 && (starve_cnt != 4'(STARVE_LIMIT)))
      starve_cnt <= starve_cnt + 4'd1;
  end

  // Round-robin pointer follows the last accepted requester
  always_ff @(posedge clk) begin
    if (rst)
      last <= REQ1;
    else if (r0_ready)
      last <= REQ0;
    else if (r1_ready)
      last <= REQ1;
  end

  // Response slot: fill on accept (drain+fill keeps it full), else drain
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_ans   <= '0;
      rsp_of    <= 1'b0;
    end else if (r0_ready || r1_ready) begin
      rsp_valid <= 1'b1;
      rsp_id    <= r1_ready;
      rsp_ans   <= alu_ans;
      rsp_of    <= alu_of;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  // Condition codes track only requester-0 accepts that ask for it
  always_ff @(posedge clk) begin
    if (rst) begin
      cc_zf <= 1'b1;
      cc_sf <= 1'b0;
      cc_of <= 1'b0;
    end else if (r0_ready && r0_set_cc) begin
      cc_zf <= (alu_ans == '0);
      cc_sf <= alu_ans[63];
      cc_of <= alu_of;
    end
  end

`ifdef ALU_PERF_CNT_EN
  // Wrapping performance counters
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_g0   <= '0;
      perf_g1   <= '0;
      perf_conf <= '0;
    end else begin
      if (r0_ready)
        perf_g0 <= perf_g0 + 32'd1;
      if (r1_ready)
        perf_g1 <= perf_g1 + 32'd1;
      if (r0_valid && r1_valid && slot_free)
        perf_conf <= perf_conf + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: a round-robin instance (u0) and a fixed-priority
// instance with STARVE_LIMIT=4 (u1) share one stimulus stream and are checked
// against a transaction-level reference model every cycle.
module tb_alu_share_ctrl;

  localparam int LIM = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        r0_valid = 1'b0;
  logic        r0_set_cc = 1'b0;
  logic [1:0]  r0_op = '0;
  logic [63:0] r0_a = '0;
  logic [63:0] r0_b = '0;
  logic        r1_valid = 1'b0;
  logic [1:0]  r1_op = '0;
  logic [63:0] r1_a = '0;
  logic [63:0] r1_b = '0;
  logic        rsp_ready = 1'b0;

  logic [1:0]  r0_rdy, r1_rdy, rv_o, id_o, of_o, zf_o, sf_o, cof_o;
  logic [63:0] ans_o [2];
`ifdef ALU_PERF_CNT_EN
  logic [31:0] pg0 [2];
  logic [31:0] pg1 [2];
  logic [31:0] pcf [2];
`endif

  always #5 clk = ~clk;

  alu_share_ctrl #(.FIX_PRIO(0), .STARVE_LIMIT(LIM)) u0 (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(r0_rdy[0]), .r0_op(r0_op), .r0_a(r0_a),
    .r0_b(r0_b), .r0_set_cc(r0_set_cc),
    .r1_valid(r1_valid), .r1_ready(r1_rdy[0]), .r1_op(r1_op), .r1_a(r1_a),
    .r1_b(r1_b),
    .rsp_valid(rv_o[0]), .rsp_ready(rsp_ready), .rsp_id(id_o[0]),
    .rsp_ans(ans_o[0]), .rsp_of(of_o[0]),
    .cc_zf(zf_o[0]), .cc_sf(sf_o[0]), .cc_of(cof_o[0])
`ifdef ALU_PERF_CNT_EN
    , .perf_g0(pg0[0]), .perf_g1(pg1[0]), .perf_conf(pcf[0])
`endif
  );

  alu_share_ctrl #(.FIX_PRIO(1), .STARVE_LIMIT(LIM)) u1 (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(r0_rdy[1]), .r0_op(r0_op), .r0_a(r0_a),
    .r0_b(r0_b), .r0_set_cc(r0_set_cc),
    .r1_valid(r1_valid), .r1_ready(r1_rdy[1]), .r1_op(r1_op), .r1_a(r1_a),
    .r1_b(r1_b),
    .rsp_valid(rv_o[1]), .rsp_ready(rsp_ready), .rsp_id(id_o[1]),
    .rsp_ans(ans_o[1]), .rsp_of(of_o[1]),
    .cc_zf(zf_o[1]), .cc_sf(sf_o[1]), .cc_of(cof_o[1])
`ifdef ALU_PERF_CNT_EN
    , .perf_g0(pg0[1]), .perf_g1(pg1[1]), .perf_conf(pcf[1])
`endif
  );

  int nvec = 0;
  int nerr = 0;

  // reference model state, one per instance
  logic        m_rv [2];
  logic        m_id [2];
  logic [63:0] m_ans [2];
  logic        m_of [2];
  logic        m_zf [2];
  logic        m_sf [2];
  logic        m_cof [2];
  int          m_last [2];
  int          m_cnt [2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // signed overflow taken from the 65-bit sign-extended result
  function automatic void alu_ref(input logic [1:0] op, input logic [63:0] a,
                                  input logic [63:0] b, output logic [63:0] y,
                                  output logic v);
    logic [64:0] w;
    w = '0;
    v = 1'b0;
    case (op)
      2'd0: begin w = {a[63], a} + {b[63], b}; v = w[64] ^ w[63]; end
      2'd1: begin w = {a[63], a} - {b[63], b}; v = w[64] ^ w[63]; end
      2'd2: w = {1'b0, a & b};
      default: w = {1'b0, a ^ b};
    endcase
    y = w[63:0];
  endfunction

  // winner among the valid requesters, -1 if none
  function automatic int pick(input int k);
    if (!r0_valid && !r1_valid) return -1;
    if (!r1_valid) return 0;
    if (!r0_valid) return 1;
    if (k == 0) return (m_last[k] == 0) ? 1 : 0;
    return (LIM != 0 && m_cnt[k] == LIM) ? 1 : 0;
  endfunction

  // one clock: check readys, advance model at the edge, check registered outputs
  task automatic step(input logic rs);
    int g [2];
    logic free;
    logic [63:0] y;
    logic v;
    rst = rs;
    #1;
    for (int k = 0; k < 2; k++) begin
      free = !m_rv[k] || rsp_ready;
      g[k] = (free && !rs) ? pick(k) : -1;
      if (!rs) begin
        chk($sformatf("u%0d.r0_ready", k), {63'd0, r0_rdy[k]}, {63'd0, g[k] == 0});
        chk($sformatf("u%0d.r1_ready", k), {63'd0, r1_rdy[k]}, {63'd0, g[k] == 1});
      end
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (rs) begin
        m_rv[k] = 1'b0; m_id[k] = 1'b0; m_ans[k] = '0; m_of[k] = 1'b0;
        m_zf[k] = 1'b1; m_sf[k] = 1'b0; m_cof[k] = 1'b0;
        m_last[k] = 1; m_cnt[k] = 0;
      end else begin
        if (k == 1) begin
          if (!r1_valid || g[k] == 1) m_cnt[k] = 0;
          else if (g[k] == 0 && m_cnt[k] < LIM) m_cnt[k] = m_cnt[k] + 1;
        end
        if (g[k] >= 0) begin
          if (g[k] == 0) alu_ref(r0_op, r0_a, r0_b, y, v);
          else           alu_ref(r1_op, r1_a, r1_b, y, v);
          m_rv[k] = 1'b1; m_id[k] = (g[k] == 1); m_ans[k] = y; m_of[k] = v;
          m_last[k] = g[k];
          if (g[k] == 0 && r0_set_cc) begin
            m_zf[k] = (y == 64'd0); m_sf[k] = y[63]; m_cof[k] = v;
          end
        end else if (rsp_ready) begin
          m_rv[k] = 1'b0;
        end
      end
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("u%0d.rsp_valid", k), {63'd0, rv_o[k]}, {63'd0, m_rv[k]});
      chk($sformatf("u%0d.rsp_id", k),    {63'd0, id_o[k]}, {63'd0, m_id[k]});
      chk($sformatf("u%0d.rsp_ans", k),   ans_o[k], m_ans[k]);
      chk($sformatf("u%0d.rsp_of", k),    {63'd0, of_o[k]}, {63'd0, m_of[k]});
      chk($sformatf("u%0d.cc_zf", k),     {63'd0, zf_o[k]}, {63'd0, m_zf[k]});
      chk($sformatf("u%0d.cc_sf", k),     {63'd0, sf_o[k]}, {63'd0, m_sf[k]});
      chk($sformatf("u%0d.cc_of", k),     {63'd0, cof_o[k]}, {63'd0, m_cof[k]});
    end
    @(negedge clk);
  endtask

  function automatic logic [63:0] rnd64();
    case ($urandom_range(0, 5))
      0: return 64'd0;
      1: return 64'h7FFF_FFFF_FFFF_FFFF;
      2: return 64'h8000_0000_0000_0000;
      3: return '1;
      4: return 64'($urandom_range(0, 15));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    // reset
    step(1'b1);
    step(1'b1);

    // r0 add 5+7 with set_cc
    rsp_ready = 1'b1;
    r0_valid = 1'b1; r0_op = 2'd0; r0_a = 64'd5; r0_b = 64'd7; r0_set_cc = 1'b1;
    step(1'b0);
    chk("plan_add_ans", ans_o[0], 64'd12);
    chk("plan_add_zf", {63'd0, zf_o[0]}, 64'd0);

    // r0 sub 3-3 -> zero
    r0_op = 2'd1; r0_a = 64'd3; r0_b = 64'd3;
    step(1'b0);
    chk("plan_sub_zf", {63'd0, zf_o[0]}, 64'd1);

    // r1 xor 0 ^ -1, CC untouched
    r0_valid = 1'b0;
    r1_valid = 1'b1; r1_op = 2'd3; r1_a = 64'd0; r1_b = '1;
    step(1'b0);
    chk("plan_xor_ans", ans_o[0], 64'hFFFF_FFFF_FFFF_FFFF);
    chk("plan_xor_id", {63'd0, id_o[0]}, 64'd1);

    // r0 add overflow
    r1_valid = 1'b0;
    r0_valid = 1'b1; r0_op = 2'd0; r0_a = 64'h7FFF_FFFF_FFFF_FFFF; r0_b = 64'd1;
    step(1'b0);
    chk("plan_ovf_of", {63'd0, of_o[0]}, 64'd1);

    // fresh reset, then both valid: alternation on u0, starvation on u1
    step(1'b1);
    r0_valid = 1'b1; r1_valid = 1'b1; r0_op = 2'd0; r1_op = 2'd1;
    r0_a = 64'd10; r0_b = 64'd1; r1_a = 64'd20; r1_b = 64'd2;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("u0_alternate", {63'd0, r0_rdy[0]}, {63'd0, (i % 2) == 0});
      chk("u1_starve", {63'd0, r1_rdy[1]}, {63'd0, (i == 4) || (i == 9)});
      step(1'b0);
    end
    // back-pressure: both readys low, outputs held
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b0);
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b0);

    // reset with a full slot and CC = Z0/S1/O1
    r1_valid = 1'b0;
    r0_op = 2'd0; r0_a = 64'h7FFF_FFFF_FFFF_FFFF; r0_b = 64'd1; r0_set_cc = 1'b1;
    step(1'b0);
    chk("pre_rst_sf", {63'd0, sf_o[0]}, 64'd1);
    rsp_ready = 1'b0; r0_valid = 1'b0;
    step(1'b1);
    chk("post_rst_valid", {63'd0, rv_o[0]}, 64'd0);
    r0_valid = 1'b1; r1_valid = 1'b1; rsp_ready = 1'b1;
    #1;
    chk("post_rst_tie", {63'd0, r0_rdy[0]}, 64'd1);
    step(1'b0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      r0_valid  = ($urandom_range(0, 3) != 0);
      r1_valid  = ($urandom_range(0, 3) != 0);
      rsp_ready = ($urandom_range(0, 3) != 0);
      r0_set_cc = $urandom_range(0, 1) != 0;
      r0_op = 2'($urandom_range(0, 3));
      r1_op = 2'($urandom_range(0, 3));
      r0_a = rnd64(); r0_b = rnd64(); r1_a = rnd64(); r1_b = rnd64();
      step($urandom_range(0, 49) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
